// File: rtl/vm_dispense_ctrl_pkg.sv
// Shared definitions for the vending-machine dispense controller.
// Holds the controller state encoding, product IDs and default
// parameter values used by the top level and its interface.
package vm_dispense_ctrl_pkg;

    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_DISPENSE = 2'd1,
        ST_CHANGE   = 2'd2
    } state_t;

    typedef enum logic {
        PROD_COFFEE = 1'b0,
        PROD_SPRITE = 1'b1
    } prod_t;

    localparam int DEF_PRICE_COFFEE = 1;
    localparam int DEF_PRICE_SPRITE = 2;
    localparam int DEF_MAX_CREDIT   = 3;
    localparam int DEF_CREDIT_W     = 2;

    function automatic int max3(input int a, input int b, input int c);
        int m;
        m = (a > b) ? a : b;
        return (m > c) ? m : c;
    endfunction

endpackage

// File: rtl/vm_dispense_ctrl_if.sv
// Front-panel / output bundle of the dispense controller.
// master: the panel side, drives the one-cycle request pulses and
//         observes the LED, strobe, change, reject, busy and credit outputs.
// slave : the controller side.
interface vm_dispense_ctrl_if #(
    parameter int CREDIT_W = 2
);
    logic                i_coin;
    logic                i_coffee;
    logic                i_sprite;
    logic                i_cancel;
    logic                o_led_coffee;
    logic                o_led_sprite;
    logic                o_coffee;
    logic                o_sprite;
    logic                o_change;
    logic                o_reject;
    logic                o_busy;
    logic [CREDIT_W-1:0] o_credit;

    modport master (
        output i_coin, i_coffee, i_sprite, i_cancel,
        input  o_led_coffee, o_led_sprite, o_coffee, o_sprite,
               o_change, o_reject, o_busy, o_credit
    );

    modport slave (
        input  i_coin, i_coffee, i_sprite, i_cancel,
        output o_led_coffee, o_led_sprite, o_coffee, o_sprite,
               o_change, o_reject, o_busy, o_credit
    );
endinterface

// File: rtl/vm_dispense_ctrl_cycle_timer.sv
// vm_cycle_timer: loadable down-counter with a done flag.
// Ports: clk, rst_n (async active-low), load_i/load_val_i (load wins),
//        dec_i (count down, holds at zero), done_o (counter is zero).
module vm_cycle_timer #(
    parameter int W = 7
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         load_i,
    input  logic [W-1:0] load_val_i,
    input  logic         dec_i,
    output logic         done_o
);
    logic [W-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (load_i) begin
            cnt_d = load_val_i;
        end else if (dec_i && cnt_q != '0) begin
            cnt_d = cnt_q - W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign done_o = (cnt_q == '0);
endmodule

// File: rtl/vm_dispense_ctrl.sv
// vm_dispense_ctrl: coin credit, coffee/sprite arbitration, timed
// dispense strobe and timed change return for the two-product machine.
// Ports: clk, rst_n (async active-low), bus (slave modport) carrying
//        i_coin/i_coffee/i_sprite/i_cancel pulses and the LED, strobe,
//        change, reject, busy and credit outputs.
// All outputs come from registers or decode registered state only.
module vm_dispense_ctrl
    import vm_dispense_ctrl_pkg::*;
#(
    parameter int PRICE_COFFEE    = DEF_PRICE_COFFEE,
    parameter int PRICE_SPRITE    = DEF_PRICE_SPRITE,
    parameter int MAX_CREDIT      = DEF_MAX_CREDIT,
    parameter int CREDIT_W        = DEF_CREDIT_W,
    parameter int DISPENSE_CYCLES = 8,
    parameter int CHANGE_GAP      = 4,
    parameter int TIMEOUT_CYCLES  = 64
) (
    input logic               clk,
    input logic               rst_n,
    vm_dispense_ctrl_if.slave bus
);
    localparam int TMR_W = $clog2(max3(DISPENSE_CYCLES, CHANGE_GAP, TIMEOUT_CYCLES) + 1);

    localparam logic [CREDIT_W-1:0] PC    = CREDIT_W'(PRICE_COFFEE);
    localparam logic [CREDIT_W-1:0] PS    = CREDIT_W'(PRICE_SPRITE);
    localparam logic [CREDIT_W-1:0] MAXC  = CREDIT_W'(MAX_CREDIT);
    localparam logic [CREDIT_W-1:0] ONE   = CREDIT_W'(1);
    localparam logic [TMR_W-1:0]    T_DSP = TMR_W'(DISPENSE_CYCLES - 1);
    localparam logic [TMR_W-1:0]    T_GAP = TMR_W'(CHANGE_GAP - 1);
    localparam logic [TMR_W-1:0]    T_TMO = TMR_W'(TIMEOUT_CYCLES - 1);

    state_t              state_q, state_d;
    logic [CREDIT_W-1:0] credit_q, credit_d;
    prod_t               rr_last_q, rr_last_d;
    prod_t               prod_q, prod_d;
    logic                reject_q, reject_d;

    logic                tmr_load, tmr_dec, tmr_done;
    logic [TMR_W-1:0]    tmr_val;
    logic                coin_ok, el_c, el_s, grant_s, any_evt;

    // One shared timer: dispense length, change gap, or idle timeout,
    // depending on the state. Each state reloads it on its way out.
    vm_cycle_timer #(.W(TMR_W)) u_timer (
        .clk        (clk),
        .rst_n      (rst_n),
        .load_i     (tmr_load),
        .load_val_i (tmr_val),
        .dec_i      (tmr_dec),
        .done_o     (tmr_done)
    );

    always_comb begin
        state_d   = state_q;
        credit_d  = credit_q;
        rr_last_d = rr_last_q;
        prod_d    = prod_q;
        reject_d  = 1'b0;
        tmr_load  = 1'b0;
        tmr_val   = '0;
        tmr_dec   = 1'b0;
        coin_ok   = bus.i_coin && (credit_q < MAXC);
        // Eligibility uses the credit held before any same-cycle coin.
        el_c      = bus.i_coffee && (credit_q >= PC);
        el_s      = bus.i_sprite && (credit_q >= PS);
        grant_s   = el_s && (!el_c || rr_last_q == PROD_COFFEE);
        any_evt   = bus.i_coin || bus.i_coffee || bus.i_sprite || bus.i_cancel;

        unique case (state_q)
            ST_IDLE: begin
                if (coin_ok) begin
                    credit_d = credit_q + ONE;
                end else if (bus.i_coin) begin
                    reject_d = 1'b1;
                end
                if (el_c || el_s) begin
                    if (el_c && el_s) begin
                        rr_last_d = grant_s ? PROD_SPRITE : PROD_COFFEE;
                    end
                    prod_d   = grant_s ? PROD_SPRITE : PROD_COFFEE;
                    credit_d = credit_q - (grant_s ? PS : PC) + CREDIT_W'(coin_ok);
                    state_d  = ST_DISPENSE;
                    tmr_load = 1'b1;
                    tmr_val  = T_DSP;
                end else if (bus.i_cancel && credit_q != '0) begin
                    state_d  = ST_CHANGE;
                    tmr_load = 1'b1;
                    tmr_val  = '0;
                end else if (any_evt || credit_q == '0) begin
                    // Idle count restarts; the timer holds the cycles still to wait.
                    tmr_load = 1'b1;
                    tmr_val  = T_TMO;
                end else if (tmr_done) begin
                    state_d  = ST_CHANGE;
                    tmr_load = 1'b1;
                    tmr_val  = '0;
                end else begin
                    tmr_dec  = 1'b1;
                end
            end

            ST_DISPENSE: begin
                reject_d = bus.i_coin;
                if (tmr_done) begin
                    tmr_load = 1'b1;
                    if (credit_q != '0) begin
                        state_d = ST_CHANGE;
                        tmr_val = '0;
                    end else begin
                        state_d = ST_IDLE;
                        tmr_val = T_TMO;
                    end
                end else begin
                    tmr_dec = 1'b1;
                end
            end

            ST_CHANGE: begin
                reject_d = bus.i_coin;
                if (tmr_done) begin
                    // This cycle carries a change pulse.
                    credit_d = credit_q - ONE;
                    tmr_load = 1'b1;
                    if (credit_q == ONE) begin
                        state_d = ST_IDLE;
                        tmr_val = T_TMO;
                    end else begin
                        tmr_val = T_GAP;
                    end
                end else begin
                    tmr_dec = 1'b1;
                end
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= ST_IDLE;
            credit_q  <= '0;
            rr_last_q <= PROD_SPRITE;
            prod_q    <= PROD_COFFEE;
            reject_q  <= 1'b0;
        end else begin
            state_q   <= state_d;
            credit_q  <= credit_d;
            rr_last_q <= rr_last_d;
            prod_q    <= prod_d;
            reject_q  <= reject_d;
        end
    end

    assign bus.o_led_coffee = (state_q == ST_IDLE) && (credit_q >= PC);
    assign bus.o_led_sprite = (state_q == ST_IDLE) && (credit_q >= PS);
    assign bus.o_coffee     = (state_q == ST_DISPENSE) && (prod_q == PROD_COFFEE);
    assign bus.o_sprite     = (state_q == ST_DISPENSE) && (prod_q == PROD_SPRITE);
    assign bus.o_change     = (state_q == ST_CHANGE) && tmr_done;
    assign bus.o_reject     = reject_q;
    assign bus.o_busy       = (state_q != ST_IDLE);
    assign bus.o_credit     = credit_q;
endmodule

// File: tb/tb_vm_dispense_ctrl.sv
// Directed bench for vm_dispense_ctrl with default parameters.
module tb_vm_dispense_ctrl;
    logic clk;
    logic rst_n;
    int   n_asserts;
    int   n_fail;

    vm_dispense_ctrl_if #(.CREDIT_W(2)) bus ();

    vm_dispense_ctrl dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_asserts++;
        assert (obs === exp)
        else begin
            n_fail++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic coin();
        bus.i_coin = 1'b1;
        tick();
        bus.i_coin = 1'b0;
    endtask

    task automatic req(input logic c, input logic s);
        bus.i_coffee = c;
        bus.i_sprite = s;
        tick();
        bus.i_coffee = 1'b0;
        bus.i_sprite = 1'b0;
    endtask

    // Called on the first strobe cycle; leaves on the cycle after the last one.
    task automatic strobe8(input string tag, input logic c, input logic s);
        for (int i = 0; i < 8; i++) begin
            chk({tag, "_coffee_on"}, bus.o_coffee, c);
            chk({tag, "_sprite_on"}, bus.o_sprite, s);
            tick();
        end
        chk({tag, "_coffee_off"}, bus.o_coffee, 0);
        chk({tag, "_sprite_off"}, bus.o_sprite, 0);
    endtask

    task automatic drain(input string tag, input int exp_changes);
        int n;
        int c;
        n = 0;
        c = 0;
        while (bus.o_busy && n < 300) begin
            if (bus.o_change) c++;
            tick();
            n++;
        end
        chk({tag, "_idle"}, bus.o_busy, 0);
        chk({tag, "_changes"}, c, exp_changes);
        chk({tag, "_credit0"}, bus.o_credit, 0);
    endtask

    initial begin
        n_asserts    = 0;
        n_fail       = 0;
        rst_n        = 1'b0;
        bus.i_coin   = 1'b0;
        bus.i_coffee = 1'b0;
        bus.i_sprite = 1'b0;
        bus.i_cancel = 1'b0;
        repeat (3) tick();
        rst_n = 1'b1;

        // Reset state
        chk("rst_credit", bus.o_credit, 0);
        chk("rst_busy", bus.o_busy, 0);
        chk("rst_led_c", bus.o_led_coffee, 0);
        chk("rst_led_s", bus.o_led_sprite, 0);
        chk("rst_strobes", {bus.o_coffee, bus.o_sprite, bus.o_change, bus.o_reject}, 0);

        // Two coins, coffee: 8-cycle strobe, one change pulse
        coin();
        coin();
        chk("t1_credit2", bus.o_credit, 2);
        chk("t1_led_c", bus.o_led_coffee, 1);
        chk("t1_led_s", bus.o_led_sprite, 1);
        req(1, 0);
        chk("t1_credit1", bus.o_credit, 1);
        chk("t1_busy", bus.o_busy, 1);
        chk("t1_led_busy", bus.o_led_coffee, 0);
        strobe8("t1", 1, 0);
        chk("t1_change", bus.o_change, 1);
        chk("t1_chg_credit", bus.o_credit, 1);
        tick();
        chk("t1_end_credit", bus.o_credit, 0);
        chk("t1_end_busy", bus.o_busy, 0);
        chk("t1_end_change", bus.o_change, 0);

        // Three coins, tie -> coffee, two change pulses 4 cycles apart
        coin();
        coin();
        coin();
        chk("t2_credit3", bus.o_credit, 3);
        req(1, 1);
        chk("t2_credit2", bus.o_credit, 2);
        strobe8("t2", 1, 0);
        chk("t2_chg0", bus.o_change, 1);
        tick();
        chk("t2_gap1", bus.o_change, 0);
        tick();
        tick();
        chk("t2_gap3", bus.o_change, 0);
        tick();
        chk("t2_chg1", bus.o_change, 1);
        chk("t2_chg1_credit", bus.o_credit, 1);
        tick();
        chk("t2_end_busy", bus.o_busy, 0);
        chk("t2_end_credit", bus.o_credit, 0);

        // Repeat -> sprite by round-robin, one change pulse
        coin();
        coin();
        coin();
        req(1, 1);
        chk("t2b_credit1", bus.o_credit, 1);
        strobe8("t2b", 0, 1);
        drain("t2b", 1);

        // Unaffordable sprite dropped, then cancel refunds
        coin();
        chk("t3_led_c", bus.o_led_coffee, 1);
        chk("t3_led_s", bus.o_led_sprite, 0);
        req(0, 1);
        chk("t3_no_busy", bus.o_busy, 0);
        chk("t3_no_sprite", bus.o_sprite, 0);
        chk("t3_credit1", bus.o_credit, 1);
        bus.i_cancel = 1'b1;
        tick();
        bus.i_cancel = 1'b0;
        chk("t3_cancel_chg", bus.o_change, 1);
        tick();
        chk("t3_credit0", bus.o_credit, 0);
        chk("t3_idle", bus.o_busy, 0);

        // Coin at saturation and during dispense is rejected
        coin();
        coin();
        coin();
        chk("t4_reject0", bus.o_reject, 0);
        coin();
        chk("t4_reject_full", bus.o_reject, 1);
        chk("t4_credit3", bus.o_credit, 3);
        tick();
        chk("t4_reject_clr", bus.o_reject, 0);
        req(1, 0);
        chk("t4_disp_credit", bus.o_credit, 2);
        coin();
        chk("t4_reject_disp", bus.o_reject, 1);
        chk("t4_disp_credit_hold", bus.o_credit, 2);
        chk("t4_still_coffee", bus.o_coffee, 1);
        drain("t4", 2);

        // Idle timeout after 64 cycles with credit
        coin();
        coin();
        repeat (63) tick();
        chk("t5_not_yet", bus.o_busy, 0);
        tick();
        chk("t5_timeout", bus.o_busy, 1);
        chk("t5_timeout_chg", bus.o_change, 1);
        drain("t5", 2);

        // Coin at idle cycle 63 restarts the count
        coin();
        repeat (62) tick();
        coin();
        chk("t5b_credit2", bus.o_credit, 2);
        tick();
        chk("t5b_restarted", bus.o_busy, 0);
        repeat (62) tick();
        chk("t5b_not_yet", bus.o_busy, 0);
        tick();
        chk("t5b_timeout", bus.o_busy, 1);
        drain("t5b", 2);

        // Reset mid-dispense; afterwards a tie grants coffee again
        coin();
        coin();
        req(1, 1);
        chk("t6_coffee", bus.o_coffee, 1);
        tick();
        tick();
        tick();
        #1 rst_n = 1'b0;
        #1;
        chk("t6_rst_coffee", bus.o_coffee, 0);
        chk("t6_rst_busy", bus.o_busy, 0);
        chk("t6_rst_credit", bus.o_credit, 0);
        tick();
        tick();
        rst_n = 1'b1;
        chk("t6_post_idle", bus.o_busy, 0);
        coin();
        coin();
        req(1, 1);
        chk("t6_tie_coffee", bus.o_coffee, 1);
        chk("t6_tie_sprite", bus.o_sprite, 0);
        drain("t6", 1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fail);
        $finish;
    end
endmodule
